// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave running on clk: pins are oversampled through 2-FF synchronizers plus an edge register.
// Receives MSB-first bytes with a one-cycle strobe and transmits from a one-entry holding register.
module spi_slave_rx #(
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       tx_underrun,
  output logic [7:0] byte_count
);

  // state  | meaning
  // IDLE   | cs_n high (or not yet seen falling since reset); miso tri-stated
  // ACTIVE | frame in progress; sclk edges shift data in and out
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_next;
  logic [2:0]  sclk_sr, cs_sr;
  logic [1:0]  mosi_sr;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;
  logic [7:0]  rx_shift, tx_shift, hold_data;
  logic        hold_full;
  logic [2:0]  bit_cnt;
  logic        start, load, shift_in, shift_out, end_frame;

  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign cs_rise   = cs_sr[1] & ~cs_sr[2];
  assign cs_fall   = ~cs_sr[1] & cs_sr[2];
  assign mosi_sync = mosi_sr[1];

  assign miso_oe  = (state == ACTIVE);
  assign busy     = (state == ACTIVE);
  assign miso     = (state == ACTIVE) & tx_shift[7];
  assign tx_ready = ~hold_full;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    load       = 1'b0;
    shift_in   = 1'b0;
    shift_out  = 1'b0;
    end_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          start      = 1'b1;
          load       = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          end_frame  = 1'b1;
        end else begin
          shift_in = sclk_rise;
          if (sclk_fall) begin
            if (bit_cnt == 3'd0) load = 1'b1;
            else                 shift_out = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      // cs_n history resets low so a pin already low after reset cannot look like a falling edge
      sclk_sr     <= 3'b000;
      cs_sr       <= 3'b000;
      mosi_sr     <= 2'b00;
      rx_shift    <= 8'd0;
      tx_shift    <= 8'd0;
      rx_data     <= 8'd0;
      bit_cnt     <= 3'd0;
      byte_count  <= 8'd0;
      hold_data   <= 8'd0;
      hold_full   <= 1'b0;
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_next;
      sclk_sr     <= {sclk_sr[1:0], sclk};
      cs_sr       <= {cs_sr[1:0], cs_n};
      mosi_sr     <= {mosi_sr[0], mosi};
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= 1'b0;

      // A write can only land while empty, so a same-cycle load always sees DEFAULT_TX
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        tx_shift    <= hold_full ? hold_data : DEFAULT_TX;
        tx_underrun <= ~hold_full;
      end else if (shift_out) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      if (start) begin
        bit_cnt    <= 3'd0;
        byte_count <= 8'd0;
        rx_shift   <= 8'd0;
      end

      if (shift_in) begin
        rx_shift <= {rx_shift[6:0], mosi_sync};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data    <= {rx_shift[6:0], mosi_sync};
          rx_valid   <= 1'b1;
          byte_count <= byte_count + 8'd1;
        end
      end

      if (end_frame) begin
        frame_done  <= 1'b1;
        frame_abort <= (bit_cnt != 3'd0);
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a bit-banged SPI master plus a scoreboard of expected rx bytes and frame ends.
// Expected miso bytes and underrun counts follow a byte-level model of tx byte availability.
module tb_spi_slave_rx;
  logic       clk = 1'b0;
  logic       rst, sclk, mosi, cs_n, tx_valid;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, busy, frame_done, frame_abort, tx_underrun;
  logic [7:0] rx_data, byte_count;

  spi_slave_rx #(.DEFAULT_TX(8'hFF)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .frame_done(frame_done), .frame_abort(frame_abort), .tx_underrun(tx_underrun),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       abort;
    logic [7:0] cnt;
    logic [7:0] data;
  } fd_t;

  int         total = 0;
  int         bad = 0;
  int         under_seen = 0;
  logic [7:0] exp_rx[$];
  fd_t        exp_fd[$];
  fd_t        fd_cur;
  logic [7:0] last_rx;

  // Frame description consumed by spi_frame
  logic [7:0] fr_rx[8];
  logic [7:0] fr_tx[8];
  logic       fr_sup[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          check("rx_data", rx_data, exp_rx.pop_front());
        end
      end
      if (frame_done) begin
        if (exp_fd.size() == 0) begin
          total++; bad++;
          $display("FAIL frame_done_unexpected: got 1 expected 0");
        end else begin
          fd_cur = exp_fd.pop_front();
          check("frame_abort", frame_abort, fd_cur.abort);
          check("byte_count", byte_count, fd_cur.cnt);
          check("rx_data_held", rx_data, fd_cur.data);
        end
      end else if (frame_abort) begin
        total++; bad++;
        $display("FAIL abort_without_done: got 1 expected 0");
      end
      if (tx_underrun) under_seen++;
    end
  end

  task automatic tx_write(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    check("tx_ready_after_write", tx_ready, 1'b0);
    tx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    exp_rx.delete();
    exp_fd.delete();
    last_rx = 8'd0;
  endtask

  // n complete bytes, then abort_bits bits of byte n; hp = clk cycles per sclk phase
  task automatic spi_frame(input int n, input int abort_bits, input int hp);
    int         nb, exp_under, under0;
    logic [7:0] rxm;
    nb = n * 8 + abort_bits;
    exp_under = 0;
    for (int k = 0; k <= n; k++) if (!fr_sup[k]) exp_under++;
    for (int k = 0; k < n; k++) begin
      exp_rx.push_back(fr_rx[k]);
      last_rx = fr_rx[k];
    end
    exp_fd.push_back('{abort: (abort_bits != 0), cnt: n[7:0], data: last_rx});
    if (fr_sup[0]) tx_write(fr_tx[0]);
    under0 = under_seen;
    rxm = 8'd0;
    fork
      begin
        cs_n = 1'b0;
        for (int i = 0; i < nb; i++) begin
          mosi = fr_rx[i / 8][7 - (i % 8)];
          wait_clk(hp);
          if (i == 0) begin
            check("busy_active", busy, 1'b1);
            check("miso_oe_active", miso_oe, 1'b1);
          end
          rxm  = {rxm[6:0], miso};
          sclk = 1'b1;
          wait_clk(hp);
          sclk = 1'b0;
          if (i % 8 == 7)
            check("miso_byte", rxm, fr_sup[i / 8] ? fr_tx[i / 8] : 8'hFF);
        end
        wait_clk(hp);
        cs_n = 1'b1;
      end
      begin
        for (int k = 1; k <= n; k++) begin
          int budget;
          budget = 0;
          do begin
            @(negedge clk);
            budget++;
          end while (!rx_valid && budget < 200);
          if (!rx_valid) begin
            total++; bad++;
            $display("FAIL rx_valid_timeout: got 0 expected 1 (byte %0d)", k - 1);
          end else if (fr_sup[k]) begin
            tx_write(fr_tx[k]);
          end
        end
      end
    join
    wait_clk(8);
    check("underrun_count", under_seen - under0, exp_under);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("fd_queue_drained", exp_fd.size(), 0);
    check("idle_miso", miso, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; tx_valid = 1'b0; tx_data = 8'd0;
    last_rx = 8'd0;
    for (int k = 0; k < 8; k++) begin fr_rx[k] = 8'd0; fr_tx[k] = 8'd0; fr_sup[k] = 1'b0; end
    do_reset();
    @(negedge clk);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_abort", frame_abort, 1'b0);
    check("rst_tx_underrun", tx_underrun, 1'b0);
    check("rst_rx_data", rx_data, 8'd0);
    check("rst_byte_count", byte_count, 8'd0);

    // single byte
    fr_rx[0] = 8'hA5; fr_tx[0] = 8'h3C; fr_sup[0] = 1'b1; fr_sup[1] = 1'b0;
    spi_frame(1, 0, 4);

    // three bytes, every load satisfied
    fr_rx[0] = 8'hA5; fr_rx[1] = 8'h3C; fr_rx[2] = 8'h7E;
    fr_tx[0] = 8'h11; fr_tx[1] = 8'h22; fr_tx[2] = 8'h33; fr_tx[3] = 8'h44;
    for (int k = 0; k < 4; k++) fr_sup[k] = 1'b1;
    spi_frame(3, 0, 4);

    // underrun on both data bytes; the trailing load is fed
    fr_rx[0] = 8'h96; fr_rx[1] = 8'h0F;
    fr_sup[0] = 1'b0; fr_sup[1] = 1'b0; fr_sup[2] = 1'b1; fr_tx[2] = 8'h55;
    spi_frame(2, 0, 5);

    // abort after 5 bits
    fr_rx[0] = 8'hC3; fr_sup[0] = 1'b1; fr_tx[0] = 8'h81;
    spi_frame(0, 5, 4);

    // reset mid-frame, ignored edges while cs_n stays low, then a clean frame
    cs_n = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 3; i++) begin
      mosi = i[0]; sclk = 1'b1; wait_clk(4); sclk = 1'b0; wait_clk(4);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mosi = ~i[0]; wait_clk(4); sclk = 1'b1; wait_clk(4); sclk = 1'b0;
    end
    wait_clk(4);
    check("post_rst_busy", busy, 1'b0);
    cs_n = 1'b1;
    wait_clk(8);
    check("post_rst_rx_data", rx_data, 8'd0);
    check("post_rst_tx_ready", tx_ready, 1'b1);
    fr_rx[0] = 8'h5A; fr_sup[0] = 1'b1; fr_tx[0] = 8'hE7; fr_sup[1] = 1'b0;
    spi_frame(1, 0, 4);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      int n, ab, hp;
      n  = $urandom_range(1, 4);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      hp = $urandom_range(4, 6);
      for (int k = 0; k < 8; k++) begin
        fr_rx[k]  = 8'($urandom);
        fr_tx[k]  = 8'($urandom);
        fr_sup[k] = ($urandom_range(0, 3) != 0);
      end
      spi_frame(n, ab, hp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
